// File: rtl/fp_add_sequencer.sv
// ============================================================================
//  Module   : fp_add_sequencer
//  Function : Fetches two operands from ROM/RAM, issues them to a clocked FP
//             adder, waits its latency and writes the sum back to scratch RAM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fp_add_sequencer #(
  parameter int ADD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        src_a_sel_i,
  input  logic        src_b_sel_i,
  input  logic [2:0]  addr_a_i,
  input  logic [2:0]  addr_b_i,
  input  logic [1:0]  dst_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [2:0]  rom_addr_o,
  output logic        rom_oe_o,
  input  logic [31:0] rom_data_i,
  output logic [1:0]  ram_addr_o,
  output logic        ram_rw_o,
  output logic        ram_oe_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic [31:0] add_op1_o,
  output logic [31:0] add_op2_o,
  output logic        add_en_o,
  input  logic [31:0] add_sum_i
);

  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_ISSUE, S_WAIT, S_WR_SETUP, S_WR_PULSE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        src_a_q, src_a_d, src_b_q, src_b_d;
  logic [2:0]  addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [1:0]  dst_q, dst_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  logic        busy_q, busy_d, done_q, done_d;
  logic [2:0]  rom_addr_q, rom_addr_d;
  logic        rom_oe_q, rom_oe_d, ram_oe_q, ram_oe_d, ram_rw_q, ram_rw_d;
  logic [1:0]  ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [31:0] add_op1_q, add_op1_d, add_op2_q, add_op2_d;
  logic        add_en_q, add_en_d;

  always_comb begin
    state_d  = state_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    dst_d    = dst_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_RD_A;
          src_a_d  = src_a_sel_i;
          src_b_d  = src_b_sel_i;
          addr_a_d = addr_a_i;
          addr_b_d = addr_b_i;
          dst_d    = dst_addr_i;
        end
      end
      S_RD_A: begin
        op_a_d  = src_a_q ? ram_rdata_i : rom_data_i;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        op_b_d  = src_b_q ? ram_rdata_i : rom_data_i;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(ADD_LAT - 1)) begin
          result_d = add_sum_i;
          state_d  = S_WR_SETUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they are registered
    // and valid for the whole duration of that state.
    busy_d      = (state_d != S_IDLE);
    done_d      = 1'b0;
    rom_oe_d    = 1'b0;
    ram_oe_d    = 1'b0;
    ram_rw_d    = 1'b0;
    add_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    add_op1_d   = add_op1_q;
    add_op2_d   = add_op2_q;

    case (state_d)
      S_RD_A: begin
        if (src_a_d) begin
          ram_oe_d   = 1'b1;
          ram_addr_d = addr_a_d[1:0];
        end else begin
          rom_oe_d   = 1'b1;
          rom_addr_d = addr_a_d;
        end
      end
      S_RD_B: begin
        if (src_b_d) begin
          ram_oe_d   = 1'b1;
          ram_addr_d = addr_b_d[1:0];
        end else begin
          rom_oe_d   = 1'b1;
          rom_addr_d = addr_b_d;
        end
      end
      S_ISSUE: begin
        add_en_d  = 1'b1;
        add_op1_d = op_a_d;
        add_op2_d = op_b_d;
      end
      S_WR_SETUP: begin
        ram_addr_d  = dst_d;
        ram_wdata_d = result_d;
      end
      S_WR_PULSE: ram_rw_d = 1'b1;
      S_DONE:     done_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_a_q     <= 1'b0;
      src_b_q     <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      dst_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rom_addr_q  <= '0;
      rom_oe_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      add_op1_q   <= '0;
      add_op2_q   <= '0;
      add_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      dst_q       <= dst_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rom_addr_q  <= rom_addr_d;
      rom_oe_q    <= rom_oe_d;
      ram_oe_q    <= ram_oe_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      add_op1_q   <= add_op1_d;
      add_op2_q   <= add_op2_d;
      add_en_q    <= add_en_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign rom_addr_o  = rom_addr_q;
  assign rom_oe_o    = rom_oe_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_rw_o    = ram_rw_q;
  assign ram_oe_o    = ram_oe_q;
  assign ram_wdata_o = ram_wdata_q;
  assign add_op1_o   = add_op1_q;
  assign add_op2_o   = add_op2_q;
  assign add_en_o    = add_en_q;

endmodule

`default_nettype wire
